// File: rtl/mux4_to_1_gate_pkg.sv
// Shared constants for the gate-level 4:1 multiplexer and its select decoder.
// Bit ordering: lane 0 and sel[0] are the leftmost (ascending-range) positions.
package mux4_to_1_gate_pkg;

    localparam int   SEL_W       = 2;
    localparam int   N_LANES     = 4;
    localparam logic OUT_RST_VAL = '0;

endpackage : mux4_to_1_gate_pkg

// File: rtl/mux4_to_1_gate_if.sv
// Data-path bundle for mux4_to_1_gate: four packed lanes, the select and the
// selected output. There is no valid/ready handshake. The master drives in/sel
// at any time, and the slave presents out either combinationally or one clock
// later.
interface mux4_to_1_gate_if #(
    parameter int WIDTH = 1
);
    import mux4_to_1_gate_pkg::*;

    logic [0:N_LANES*WIDTH-1] in;
    logic [0:SEL_W-1]         sel;
    logic [0:WIDTH-1]         out;

    modport master (output in, output sel, input  out);
    modport slave  (input  in, input  sel, output out);

endinterface : mux4_to_1_gate_if

// File: rtl/mux4_sel_decode.sv
// Gate-level 2-to-4 one-hot select decoder built from NOT/AND primitives.
// sel[0] is the MSB: dec[{sel[0],sel[1]}] is the single high line.
// With MUX4_TO_1_GATE_STROBE_EN defined, en is an extra AND input on every line.
module mux4_sel_decode
    import mux4_to_1_gate_pkg::*;
(
    input  wire [0:SEL_W-1]   sel,
`ifdef MUX4_TO_1_GATE_STROBE_EN
    input  wire               en,
`endif
    output wire [0:N_LANES-1] dec
);

    wire sel0_n;
    wire sel1_n;

    not u_not0 (sel0_n, sel[0]);
    not u_not1 (sel1_n, sel[1]);

`ifdef MUX4_TO_1_GATE_STROBE_EN
    and u_dec0 (dec[0], sel0_n, sel1_n, en);
    and u_dec1 (dec[1], sel0_n, sel[1], en);
    and u_dec2 (dec[2], sel[0], sel1_n, en);
    and u_dec3 (dec[3], sel[0], sel[1], en);
`else
    and u_dec0 (dec[0], sel0_n, sel1_n);
    and u_dec1 (dec[1], sel0_n, sel[1]);
    and u_dec2 (dec[2], sel[0], sel1_n);
    and u_dec3 (dec[3], sel[0], sel[1]);
`endif

endmodule : mux4_sel_decode

// File: rtl/mux4_to_1_gate.sv
// Gate-level 4:1 multiplexer, the leaf cell of the mux16to1 tree.
// Lane k = bus.in[k*WIDTH +: WIDTH]. Lane 0 is leftmost, and sel[0] is the MSB.
// REG_OUT=0 gives a purely combinational path. REG_OUT=1 registers out, with a
// synchronous active-high reset to zero.
// Optional macro MUX4_TO_1_GATE_STROBE_EN adds the en port: zero output when
// combinational, and hold when registered.
module mux4_to_1_gate
    import mux4_to_1_gate_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MUX4_TO_1_GATE_STROBE_EN
    input  logic             en,
`endif
    mux4_to_1_gate_if.slave  bus
);

    wire [0:N_LANES-1] dec;
    wire [0:WIDTH-1]   mux_comb;

    mux4_sel_decode u_dec (
        .sel (bus.sel),
`ifdef MUX4_TO_1_GATE_STROBE_EN
        .en  (en),
`endif
        .dec (dec)
    );

    // Per bit: AND each lane bit with its decode line, then OR the four terms.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        wire [0:N_LANES-1] term;
        for (genvar k = 0; k < N_LANES; k++) begin : g_lane
            and u_and (term[k], bus.in[k*WIDTH + b], dec[k]);
        end
        or u_or (mux_comb[b], term[0], term[1], term[2], term[3]);
    end

    if (REG_OUT != 0) begin : g_reg
        logic [0:WIDTH-1] out_q;

        // Output register: rst wins, and otherwise it captures the gated mux result.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= {WIDTH{OUT_RST_VAL}};
`ifdef MUX4_TO_1_GATE_STROBE_EN
            end else if (en) begin
`else
            end else begin
`endif
                out_q <= mux_comb;
            end
        end

        assign bus.out = out_q;
    end else begin : g_comb
        // clk and rst have no function on the combinational path.
        wire unused_clk_rst = &{1'b0, clk, rst};

        assign bus.out = mux_comb;
    end

endmodule : mux4_to_1_gate

// File: tb/tb_mux4_to_1_gate.sv
// Directed bench for mux4_to_1_gate. It runs a WIDTH=1 combinational instance
// and a WIDTH=8 registered instance. Build with +define+MUX4_TO_1_GATE_STROBE_EN
// to cover the en port.
module tb_mux4_to_1_gate;

    localparam logic [7:0] LANES_R [4] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef MUX4_TO_1_GATE_STROBE_EN
    logic en_c;
    logic en_r;
`endif

    mux4_to_1_gate_if #(.WIDTH(1)) bus_c ();
    mux4_to_1_gate_if #(.WIDTH(8)) bus_r ();

    mux4_to_1_gate #(.WIDTH(1), .REG_OUT(0)) u_dut_c (
        .clk (clk),
        .rst (rst),
`ifdef MUX4_TO_1_GATE_STROBE_EN
        .en  (en_c),
`endif
        .bus (bus_c.slave)
    );

    mux4_to_1_gate #(.WIDTH(8), .REG_OUT(1)) u_dut_r (
        .clk (clk),
        .rst (rst),
`ifdef MUX4_TO_1_GATE_STROBE_EN
        .en  (en_r),
`endif
        .bus (bus_r.slave)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_c(input logic [3:0] data, input logic [1:0] idx);
        bus_c.in  = data;
        bus_c.sel = idx;
        #1;
    endtask

    task automatic drive_r_lanes(input logic [7:0] l0, input logic [7:0] l1,
                                 input logic [7:0] l2, input logic [7:0] l3);
        bus_r.in = {l0, l1, l2, l3};
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] data;
    logic [1:0] idx;
    logic [7:0] prev;

    initial begin
        rst       = 1'b1;
        bus_c.in  = '0;
        bus_c.sel = '0;
        bus_r.sel = '0;
        drive_r_lanes(LANES_R[0], LANES_R[1], LANES_R[2], LANES_R[3]);
`ifdef MUX4_TO_1_GATE_STROBE_EN
        en_c = 1'b1;
        en_r = 1'b1;
`endif

        // Combinational one-hot sweep (lane 0 is the leftmost bit).
        drive_c(4'b1000, 2'b00); check_val("onehot0", {7'b0, bus_c.out}, 8'h01);
        drive_c(4'b0100, 2'b01); check_val("onehot1", {7'b0, bus_c.out}, 8'h01);
        drive_c(4'b0010, 2'b10); check_val("onehot2", {7'b0, bus_c.out}, 8'h01);
        drive_c(4'b0001, 2'b11); check_val("onehot3", {7'b0, bus_c.out}, 8'h01);

        // Isolation: every lane is 1 except the selected lane.
        drive_c(4'b0111, 2'b00); check_val("iso0", {7'b0, bus_c.out}, 8'h00);
        drive_c(4'b1011, 2'b01); check_val("iso1", {7'b0, bus_c.out}, 8'h00);
        drive_c(4'b1101, 2'b10); check_val("iso2", {7'b0, bus_c.out}, 8'h00);
        drive_c(4'b1110, 2'b11); check_val("iso3", {7'b0, bus_c.out}, 8'h00);

        // Exhaustive WIDTH=1: expected bit is at position idx counted from the left.
        for (int v = 0; v < 64; v++) begin
            data = v[5:2];
            idx  = v[1:0];
            drive_c(data, idx);
            check_val("exh", {7'b0, bus_c.out}, {7'b0, data[3 - idx]});
        end

        // Registered instance: reset state.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_state", bus_r.out, 8'h00);

        // Step sel 00..11. The new lane appears only after the next edge.
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            rst       = 1'b0;
            bus_r.sel = s[1:0];
            exp_q.push_back(LANES_R[s]);
            prev = (s == 0) ? 8'h00 : LANES_R[s-1];
            check_val("pre_edge", bus_r.out, prev);
            @(posedge clk); #1;
            check_val("latency", bus_r.out, exp_q.pop_front());
        end

        // Reset while sel=10 selects F0, then release.
        @(negedge clk);
        bus_r.sel = 2'b10;
        rst       = 1'b1;
        @(posedge clk); #1;
        check_val("rst_mid", bus_r.out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("rst_release", bus_r.out, 8'hF0);

        // Non-selected lanes change. The output stays on lane 2.
        @(negedge clk);
        drive_r_lanes(8'h00, 8'hFF, 8'hF0, 8'hFF);
        @(posedge clk); #1;
        check_val("reg_iso", bus_r.out, 8'hF0);

        // Simultaneous change of in and sel.
        @(negedge clk);
        drive_r_lanes(8'h11, 8'h22, 8'h33, 8'h44);
        bus_r.sel = 2'b11;
        @(posedge clk); #1;
        check_val("simul", bus_r.out, 8'h44);

`ifdef MUX4_TO_1_GATE_STROBE_EN
        // Combinational path with en low: zero for every sel.
        en_c = 1'b0;
        for (int s = 0; s < 4; s++) begin
            drive_c(4'b1111, s[1:0]);
            check_val("en0_comb", {7'b0, bus_c.out}, 8'h00);
        end
        en_c = 1'b1;
        drive_c(4'b1111, 2'b10);
        check_val("en1_comb", {7'b0, bus_c.out}, 8'h01);

        // Registered path with en low holds its value.
        @(negedge clk);
        en_r      = 1'b0;
        bus_r.sel = 2'b00;
        @(posedge clk); #1;
        check_val("en0_hold", bus_r.out, 8'h44);

        // rst wins over en low.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("en0_rst", bus_r.out, 8'h00);

        @(negedge clk);
        rst  = 1'b0;
        en_r = 1'b1;
        @(posedge clk); #1;
        check_val("en1_reg", bus_r.out, 8'h11);
`endif

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux4_to_1_gate
